exec_unit: RTL and testbench

Execute stage of the 16-bit RISC core. It sits directly downstream of the 8×16 register file: it consumes the two read-port operands (rega/regb) with a decoded opcode and destination index, and computes the result. It also generates the register-file write port (wdata/wadd/write) and the condition flags. Single-cycle ALU/shift ops complete in 1 cycle; MUL uses an iterative 16-cycle shift-add engine and back-pressures the decoder via a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mul_iter.sv | 53 +++++
 rtl/exec_unit.sv | 171 +++++++++++++++++
 tb/tb_exec_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core:
// datapath sizes, opcodes and execute-stage FSM states.
package cpu_pkg;

    localparam int WIDTH = 16;
    localparam int AREGS = 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_MOV = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high during the last iteration; product then shows the final value.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] addend;
    logic [W-1:0]   mplr_q;
    logic [3:0]     cnt_q;
    logic           busy_q;

    // product is the accumulator after the current iteration's add
    assign addend  = mplr_q[0] ? mcand_q : '0;
    assign product = acc_q + addend;
    assign done    = busy_q && (cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            acc_q   <= '0;
            mcand_q <= {{W{1'b0}}, multiplicand};
            mplr_q  <= multiplier;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            acc_q   <= product;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + 4'd1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/shift ops plus a 16-cycle iterative MUL,
// driving the register-file write port and condition flags.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int AREGS = cpu_pkg::AREGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    input  logic [AREGS-1:0] dest,
    output logic [WIDTH-1:0] wdata,
    output logic [AREGS-1:0] wadd,
    output logic             write,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    state_t           state_q;
    logic [WIDTH-1:0] wdata_q;
    logic [AREGS-1:0] wadd_q;
    logic [AREGS-1:0] dest_q;
    logic             write_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl_t;
    logic [2*WIDTH-1:0] shr_t;
    logic [2*WIDTH-1:0] sra_t;
    logic [3:0]         amt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_wr;
    logic             alu_fl;

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    // Shifts run in a double-width window so the bit shifted out
    // lands at a fixed position next to the result.
    assign amt   = regb[3:0];
    assign sum   = {1'b0, rega} + {1'b0, regb};
    assign diff  = {1'b0, rega} - {1'b0, regb};
    assign shl_t = {{WIDTH{1'b0}}, rega} << amt;
    assign shr_t = {rega, {WIDTH{1'b0}}} >> amt;
    assign sra_t = $signed({rega, {WIDTH{1'b0}}}) >>> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
            end
            OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_wr  = 1'b0;
            end
            OP_AND: alu_res = rega & regb;
            OP_OR:  alu_res = rega | regb;
            OP_XOR: alu_res = rega ^ regb;
            OP_NOT: alu_res = ~rega;
            OP_MOV: alu_res = rega;
            OP_SHL: begin
                alu_res = shl_t[WIDTH-1:0];
                alu_c   = shl_t[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_t[2*WIDTH-1:WIDTH];
                alu_c   = shr_t[WIDTH-1];
            end
            OP_SRA: begin
                alu_res = sra_t[2*WIDTH-1:WIDTH];
                alu_c   = sra_t[WIDTH-1];
            end
            default: begin
                alu_wr = 1'b0;
                alu_fl = 1'b0;
            end
        endcase
    end

    mul_iter #(
        .W(WIDTH)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (rega),
        .multiplier   (regb),
        .done         (mul_done),
        .product      (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wdata_q <= '0;
            wadd_q  <= '0;
            dest_q  <= '0;
            write_q <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && op == OP_MUL) begin
                        state_q <= ST_MUL;
                        dest_q  <= dest;
                    end else if (accept) begin
                        write_q <= alu_wr;
                        if (alu_wr) begin
                            wdata_q <= alu_res;
                            wadd_q  <= dest;
                        end
                        if (alu_fl) begin
                            z_q <= (alu_res == '0);
                            n_q <= alu_res[WIDTH-1];
                            c_q <= alu_c;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q <= ST_IDLE;
                        write_q <= 1'b1;
                        wdata_q <= mul_prod[WIDTH-1:0];
                        wadd_q  <= dest_q;
                        z_q     <= (mul_prod[WIDTH-1:0] == '0);
                        n_q     <= mul_prod[WIDTH-1];
                        c_q     <= |mul_prod[2*WIDTH-1:WIDTH];
                    end
                end
            endcase
        end
    end

    assign wdata  = wdata_q;
    assign wadd   = wadd_q;
    assign write  = write_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, hand-built
// multi-cycle sequences and randomized ops against an arithmetic model.
module tb_exec_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] rega;
    logic [15:0] regb;
    logic [2:0]  dest;
    logic [15:0] wdata;
    logic [2:0]  wadd;
    logic        write;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] m_wdata;
    logic [2:0]  m_wadd;
    logic        m_z, m_n, m_c;

    exec_unit #(.WIDTH(16), .AREGS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rega     (rega),
        .regb     (regb),
        .dest     (dest),
        .wdata    (wdata),
        .wadd     (wadd),
        .write    (write),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  d;
        logic        wr;
        logic [15:0] wd;
        logic [2:0]  wa;
        logic        z;
        logic        n;
        logic        c;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the op definitions.
    task automatic model_op(input logic [3:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] d,
                            output logic wr);
        int unsigned ua, ub, amt;
        longint unsigned p;
        int sa;
        logic [31:0] r;
        logic c, fl;
        ua = a;
        ub = b;
        amt = ub % 16;
        wr = 1'b1;
        fl = 1'b1;
        c = 1'b0;
        r = 0;
        case (o)
            OP_ADD: begin
                r = ua + ub;
                c = (r > 32'hFFFF);
            end
            OP_SUB, OP_CMP: begin
                r = (ua - ub) & 32'hFFFF;
                c = (ua < ub);
                wr = (o == OP_SUB);
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOT: r = 32'hFFFF - ua;
            OP_MOV: r = ua;
            OP_SHL: begin
                r = (ua << amt) & 32'hFFFF;
                c = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1);
            end
            OP_SHR: begin
                r = ua >> amt;
                c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
            end
            OP_SRA: begin
                sa = (ua >= 32'h8000) ? int'(ua) - 65536 : int'(ua);
                r = (sa >>> amt) & 32'hFFFF;
                c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
            end
            OP_MUL: begin
                p = longint'(ua) * longint'(ub);
                r = 32'(p & 64'hFFFF);
                c = ((p >> 16) != 0);
            end
            default: begin
                wr = 1'b0;
                fl = 1'b0;
            end
        endcase
        if (fl) begin
            m_z = (r[15:0] == 16'h0);
            m_n = r[15];
            m_c = c;
        end
        if (wr) begin
            m_wdata = r[15:0];
            m_wadd = d;
        end
    endtask

    task automatic check_model(input string tag, input logic wr);
        chk({tag, ".write"}, write, wr);
        chk({tag, ".wdata"}, wdata, m_wdata);
        chk({tag, ".wadd"}, wadd, m_wadd);
        chk({tag, ".z"}, flag_z, m_z);
        chk({tag, ".n"}, flag_n, m_n);
        chk({tag, ".c"}, flag_c, m_c);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge.
    task automatic exec(input string tag, input logic [3:0] o,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
        logic wr;
        int lat;
        chk({tag, ".ready"}, in_ready, 1'b1);
        op = o;
        rega = a;
        regb = b;
        dest = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_op(o, a, b, d, wr);
        if (o == OP_MUL) begin
            lat = 1;
            while (!write && lat < 24) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk({tag, ".mul_lat"}, lat, 17);
        end
        check_model(tag, wr);
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic wr;
        int wcnt;
        logic [3:0] sops [4];

        reset = 1'b1;
        in_valid = 1'b0;
        op = '0;
        rega = '0;
        regb = '0;
        dest = '0;
        m_wdata = '0;
        m_wadd = '0;
        m_z = 1'b0;
        m_n = 1'b0;
        m_c = 1'b0;

        tv.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 3'd3, 1'b1, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1});
        tv.push_back('{OP_SUB, 16'h0002, 16'h0003, 3'd5, 1'b1, 16'hFFFF, 3'd5, 1'b0, 1'b1, 1'b1});
        tv.push_back('{OP_CMP, 16'h0007, 16'h0007, 3'd6, 1'b0, 16'hFFFF, 3'd5, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'd13,  16'h1111, 16'h2222, 3'd7, 1'b0, 16'hFFFF, 3'd5, 1'b1, 1'b0, 1'b0});
        tv.push_back('{OP_SHL, 16'h8001, 16'h0011, 3'd1, 1'b1, 16'h0002, 3'd1, 1'b0, 1'b0, 1'b1});
        tv.push_back('{OP_SRA, 16'h8000, 16'h000F, 3'd2, 1'b1, 16'hFFFF, 3'd2, 1'b0, 1'b1, 1'b0});
        tv.push_back('{OP_SHR, 16'h1234, 16'h0000, 3'd4, 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0});
        tv.push_back('{OP_SHR, 16'h8001, 16'h0010, 3'd4, 1'b1, 16'h8001, 3'd4, 1'b0, 1'b1, 1'b0});
        tv.push_back('{OP_SHR, 16'h0003, 16'h0001, 3'd0, 1'b1, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b1});
        tv.push_back('{OP_AND, 16'hF0F0, 16'h0FF0, 3'd0, 1'b1, 16'h00F0, 3'd0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{OP_OR,  16'h1200, 16'h0034, 3'd7, 1'b1, 16'h1234, 3'd7, 1'b0, 1'b0, 1'b0});
        tv.push_back('{OP_XOR, 16'hFFFF, 16'hFFFF, 3'd6, 1'b1, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0});
        tv.push_back('{OP_NOT, 16'h0000, 16'h1234, 3'd3, 1'b1, 16'hFFFF, 3'd3, 1'b0, 1'b1, 1'b0});
        tv.push_back('{OP_MOV, 16'h8000, 16'h0000, 3'd2, 1'b1, 16'h8000, 3'd2, 1'b0, 1'b1, 1'b0});

        // reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.wdata", wdata, 16'h0);
        chk("rst.wadd", wadd, 3'd0);
        chk("rst.write", write, 1'b0);
        chk("rst.flags", {flag_z, flag_n, flag_c}, 3'b000);
        chk("rst.ready_low", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", in_ready, 1'b1);

        // directed table, streamed one op per cycle
        foreach (tv[i]) begin
            chk($sformatf("tv%0d.ready", i), in_ready, 1'b1);
            op = tv[i].op;
            rega = tv[i].a;
            regb = tv[i].b;
            dest = tv[i].d;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            model_op(tv[i].op, tv[i].a, tv[i].b, tv[i].d, wr);
            chk($sformatf("tv%0d.write", i), write, tv[i].wr);
            chk($sformatf("tv%0d.wdata", i), wdata, tv[i].wd);
            chk($sformatf("tv%0d.wadd", i), wadd, tv[i].wa);
            chk($sformatf("tv%0d.znc", i), {flag_z, flag_n, flag_c},
                {tv[i].z, tv[i].n, tv[i].c});
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // back-to-back ADD, AND, MOV, NOP
        sops[0] = OP_ADD;
        sops[1] = OP_AND;
        sops[2] = OP_MOV;
        sops[3] = 4'd14;
        wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            op = sops[i];
            rega = 16'($urandom);
            regb = 16'($urandom);
            dest = 3'(i + 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            model_op(op, rega, regb, dest, wr);
            if (write) wcnt++;
            check_model($sformatf("stream%0d", i), wr);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream.writes", wcnt, 3);

        // MUL 300x300 with a queued ADD held behind it
        op = OP_MUL;
        rega = 16'd300;
        regb = 16'd300;
        dest = 3'd4;
        in_valid = 1'b1;
        @(posedge clk);
        model_op(OP_MUL, 16'd300, 16'd300, 3'd4, wr);
        @(negedge clk);
        op = OP_ADD;
        rega = 16'd1;
        regb = 16'd2;
        dest = 3'd1;
        wcnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready || write) wcnt++;
            @(negedge clk);
        end
        chk("mul300.busy_cycles", wcnt, 0);
        chk("mul300.write", write, 1'b1);
        chk("mul300.wdata", wdata, 16'h5F90);
        chk("mul300.wadd", wadd, 3'd4);
        chk("mul300.c", flag_c, 1'b1);
        chk("mul300.ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_op(OP_ADD, 16'd1, 16'd2, 3'd1, wr);
        check_model("mul300.queued_add", wr);
        @(negedge clk);

        // randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            exec($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                 pick(), pick(), 3'($urandom));
        end

        // reset during MUL iteration 8
        op = OP_MUL;
        rega = 16'h1234;
        regb = 16'h5678;
        dest = 3'd6;
        in_valid = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        wcnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (write) wcnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.wdata", wdata, 16'h0);
        chk("abort.wadd", wadd, 3'd0);
        chk("abort.write", write, 1'b0);
        chk("abort.flags", {flag_z, flag_n, flag_c}, 3'b000);
        chk("abort.ready_low", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort.ready_after", in_ready, 1'b1);
        repeat (20) begin
            @(posedge clk);
            #1;
            if (write) wcnt++;
        end
        chk("abort.no_write", wcnt, 0);
        m_wdata = '0;
        m_wadd = '0;
        m_z = 1'b0;
        m_n = 1'b0;
        m_c = 1'b0;
        @(negedge clk);
        exec("mul3x4", OP_MUL, 16'd3, 16'd4, 3'd2);
        chk("mul3x4.result", wdata, 16'd12);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
